counter_sequencer: RTL and testbench
====================================

# counter_sequencer

Run-control sequencer for the team's synchronous binary up-counter datapath. It owns a WIDTH-bit count register and gates its advance through a programmable prescaler. It runs the count from 0 to a programmable terminal value in one-shot or periodic mode, with start, pause/resume and abort control. It sits between software-style control strobes and anything that consumes `count`, `tick` or `done`.

## Interface
Parameters:
- `WIDTH`, 4, count and terminal width
- `PSC_W`, 4, prescaler width

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `start`  in  1  level-sampled strobe; launch from IDLE/DONE, resume from HOLD
- `pause`  in  1  freeze the run (RUN -> HOLD)
- `abort`  in  1  return to IDLE from any state
- `mode`  in  1  0 = one-shot, 1 = periodic; latched on launch
- `terminal`  in  WIDTH  last count value; latched on launch
- `prescale`  in  PSC_W  count advances every prescale+1 cycles; latched on launch
- `count`  out  WIDTH  current count, registered
- `busy`  out  1  high in RUN and HOLD
- `paused`  out  1  high in HOLD
- `tick`  out  1  one-cycle pulse: terminal step taken
- `done`  out  1  level, high in DONE (one-shot complete)

## Operation
- States: IDLE, RUN, HOLD, DONE. Internal regs: `count`, prescaler `psc`, latched `term_l`, `psc_l`, `mode_l`.
- Command priority per cycle: abort > pause > start. Only one command acts per edge.
- IDLE: count=0, psc=0. On start, latch terminal/prescale/mode, clear count and psc, and go to RUN. pause is ignored.
- RUN, no command:
  - If psc != psc_l: psc+1.
  - Else: psc<=0 and a step occurs.
  - Step with count != term_l: count+1.
  - Step with count == term_l: tick=1 next cycle. If mode_l=1, count<=0 and stay in RUN. If mode_l=0, count holds term_l and go to DONE.
- RUN + pause: go to HOLD. count and psc are frozen, and no step occurs even if one was due that cycle.
- RUN + start: ignored. Inputs are not re-latched mid-run.
- HOLD: everything frozen. start returns to RUN with psc continuing from its frozen value. pause is ignored.
- DONE: count=term_l, done=1. start re-launches exactly as from IDLE, re-latching inputs. pause is ignored.
- abort from any state: IDLE, count=0, psc=0, tick=0 next cycle.
- terminal=0: every step is a terminal step. In periodic mode tick fires every prescale+1 cycles.
- Arithmetic:
  - count never exceeds term_l, so no WIDTH overflow.
  - psc compare is unsigned equality.
  - terminal = 2^WIDTH−1 is legal and gives full-range wrap to 0.

## Timing
- Reset values: count=0, busy=0, paused=0, tick=0, done=0, state=IDLE, psc=0, latches=0.
- All outputs are registered and reflect state after each edge. There are no combinational input-to-output paths.
- Launch: start sampled at edge E0 gives busy=1 and count=0 after E0.
- With P=prescale and T=terminal:
  - count reaches k after edge E0+k(P+1).
  - tick is high for the cycle after edge E0+(T+1)(P+1).
  - Periodic tick spacing is (T+1)(P+1) cycles.
- One-shot: in the cycle after the terminal edge, tick=1, done=1 and busy=0. tick drops the following cycle; done stays high.
- Pause/resume adds exactly the number of cycles spent in HOLD, plus zero; resume takes effect at the edge that samples start.
- Reset asserted mid-run: outputs go to reset values asynchronously. After deassertion the block sits in IDLE until a new start.

## Test plan
- Reset, then start with mode=1, terminal=3, prescale=0. Required: count 0,1,2,3,0,1… on successive cycles, tick every 4th cycle when count returns to 0, busy=1 throughout.
- Start with mode=0, terminal=5, prescale=2. Required: count increments every 3 cycles to 5. tick and done rise together 18 cycles after the start edge. tick is one cycle wide; done and count=5 are held. A second start relaunches from 0.
- Periodic run with terminal=7, prescale=1, pause asserted at count=4 for 10 cycles, then start. Required: paused=1, count stays 4 with no tick during HOLD. Total time to the next tick grows by exactly 10 cycles.
- abort and pause asserted together while in RUN at count=2. Required: IDLE next cycle with count=0, busy=0, paused=0. While running, change terminal/mode and assert start. Required: no effect on the current run.
- terminal=0, prescale=0, periodic. Required: tick high every cycle and count constant 0. Same setup with terminal=15, WIDTH=4: count wraps 15→0 with tick.
- Assert reset asynchronously mid-run at count=9. Required: all outputs 0 before the next clock edge. Then start: the run begins from count 0 with newly latched parameters.

Source files
------------

// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Run-control sequencer for a binary up-counter. A launch latches the
//   terminal value, prescaler reload and mode. The count then advances once
//   every prescale+1 cycles until it reaches the terminal value. In one-shot
//   mode the run then parks in DONE. In periodic mode it wraps to 0 and keeps
//   running. Runs can be paused and resumed, and abort returns to IDLE.
//
// Ports
//   clk       sole clock, rising edge
//   reset     asynchronous active-high reset, clears all state
//   start     launch (IDLE/DONE) or resume (HOLD)
//   pause     RUN -> HOLD
//   abort     any state -> IDLE (highest priority)
//   mode      0 = one-shot, 1 = periodic, latched on launch
//   terminal  last count value, latched on launch
//   prescale  count advances every prescale+1 cycles, latched on launch
//   count     current count
//   busy      high in RUN and HOLD
//   paused    high in HOLD
//   tick      one-cycle pulse after a terminal step
//   done      high in DONE
module counter_sequencer #(
  parameter int WIDTH = 4,
  parameter int PSC_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             mode,
  input  logic [WIDTH-1:0] terminal,
  input  logic [PSC_W-1:0] prescale,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             paused,
  output logic             tick,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] count_nx, term_l, term_nx;
  logic [PSC_W-1:0] psc, psc_nx, psc_l, pscl_nx;
  logic             mode_l, mode_nx, tick_nx;
  logic             advance;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      psc    <= '0;
      term_l <= '0;
      psc_l  <= '0;
      mode_l <= 1'b0;
      tick   <= 1'b0;
    end else begin
      state  <= state_nx;
      count  <= count_nx;
      psc    <= psc_nx;
      term_l <= term_nx;
      psc_l  <= pscl_nx;
      mode_l <= mode_nx;
      tick   <= tick_nx;
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    psc_nx   = psc;
    term_nx  = term_l;
    pscl_nx  = psc_l;
    mode_nx  = mode_l;
    tick_nx  = 1'b0;
    advance  = 1'b0;

    if (abort) begin
      state_nx = IDLE;
      count_nx = '0;
      psc_nx   = '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state_nx = RUN;
            count_nx = '0;
            psc_nx   = '0;
            term_nx  = terminal;
            pscl_nx  = prescale;
            mode_nx  = mode;
          end
        end
        RUN: begin
          // A pause edge swallows any step that was due on it.
          if (pause) state_nx = HOLD;
          else       advance  = 1'b1;
        end
        HOLD: begin
          // The resume edge advances like a normal run edge. A pause therefore
          // costs exactly the cycles spent in HOLD.
          if (start) begin
            state_nx = RUN;
            advance  = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end

    if (advance) begin
      if (psc != psc_l) begin
        psc_nx = psc + 1'b1;
      end else begin
        psc_nx = '0;
        if (count != term_l) begin
          count_nx = count + 1'b1;
        end else begin
          tick_nx = 1'b1;
          if (mode_l) count_nx = '0;
          else        state_nx = DONE;
        end
      end
    end
  end

  assign busy   = (state == RUN) || (state == HOLD);
  assign paused = (state == HOLD);
  assign done   = (state == DONE);

endmodule

// File: tb/tb_counter_sequencer.sv
// Testbench for counter_sequencer.
// Each cycle the expected outputs are pushed to a queue when the inputs are
// driven. They are popped and compared one time unit after the clock edge.
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, pause, abort, mode;
  logic [3:0] terminal, prescale;
  logic [3:0] count;
  logic       busy, paused, tick, done;

  int total = 0;
  int bad   = 0;
  int ecnt  = 0;

  logic [7:0] sb[$];

  // reference model state
  int         ms;  // 0 idle 1 run 2 hold 3 done
  logic [3:0] m_cnt, m_psc, m_term, m_pl;
  logic       m_mode, m_tick;

  counter_sequencer #(.WIDTH(4), .PSC_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .abort(abort),
    .mode(mode), .terminal(terminal), .prescale(prescale),
    .count(count), .busy(busy), .paused(paused), .tick(tick), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    ms = 0; m_cnt = 0; m_psc = 0; m_term = 0; m_pl = 0; m_mode = 0; m_tick = 0;
  endtask

  task automatic m_adv();
    if (m_psc != m_pl) m_psc = m_psc + 1;
    else begin
      m_psc = 0;
      if (m_cnt == m_term) begin
        m_tick = 1;
        if (m_mode) m_cnt = 0;
        else ms = 3;
      end else m_cnt = m_cnt + 1;
    end
  endtask

  task automatic m_step(input logic st, pa, ab, md, input logic [3:0] tm, ps);
    m_tick = 0;
    if (ab) begin
      ms = 0; m_cnt = 0; m_psc = 0;
    end else if (ms == 0 || ms == 3) begin
      if (st) begin
        ms = 1; m_cnt = 0; m_psc = 0; m_term = tm; m_pl = ps; m_mode = md;
      end
    end else if (ms == 1) begin
      if (pa) ms = 2;
      else m_adv();
    end else begin
      if (st) begin ms = 1; m_adv(); end
    end
  endtask

  task automatic cyc(input logic st, pa, ab, md, input logic [3:0] tm, ps);
    logic [7:0] e;
    start = st; pause = pa; abort = ab; mode = md; terminal = tm; prescale = ps;
    if (reset) m_reset();
    else m_step(st, pa, ab, md, tm, ps);
    sb.push_back({m_cnt, (ms == 1 || ms == 2), (ms == 2), m_tick, (ms == 3)});
    @(posedge clk);
    #1;
    ecnt++;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("count", count, e[7:4]);
      chk("busy", busy, e[3]);
      chk("paused", paused, e[2]);
      chk("tick", tick, e[1]);
      chk("done", done, e[0]);
    end
  endtask

  task automatic nop();
    cyc(1'b0, 1'b0, 1'b0, mode, terminal, prescale);
  endtask

  task automatic run_until_count(input logic [3:0] v, input int maxc);
    int n = 0;
    while (count != v && n < maxc) begin nop(); n++; end
    chk("reach_count", count, v);
  endtask

  initial begin
    int e0, maxc;
    logic seen;
    reset = 1'b1; start = 0; pause = 0; abort = 0; mode = 0; terminal = 0; prescale = 0;
    m_reset();
    #2;
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tick", tick, 0);
    chk("rst_done", done, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    nop();

    // periodic, T=3, P=0: count 0,1,2,3,0..., tick on each return to 0
    cyc(1, 0, 0, 1, 4'd3, 4'd0);
    for (int k = 1; k <= 12; k++) begin
      nop();
      chk("t1_count", count, k % 4);
      chk("t1_tick", tick, (k % 4) == 0);
      chk("t1_busy", busy, 1);
    end

    // one-shot, T=5, P=2: tick and done 18 edges after launch
    cyc(0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 4'd5, 4'd2);
    e0 = ecnt;
    while (tick !== 1'b1 && ecnt - e0 < 25) nop();
    chk("t2_tick_lat", ecnt - e0, 18);
    chk("t2_done", done, 1);
    chk("t2_busy", busy, 0);
    chk("t2_count", count, 5);
    nop();
    chk("t2_tick_w", tick, 0);
    chk("t2_done_hold", done, 1);
    nop();
    chk("t2_count_hold", count, 5);
    cyc(1, 0, 0, 0, 4'd5, 4'd2);
    chk("t2_relaunch_cnt", count, 0);
    chk("t2_relaunch_busy", busy, 1);

    // periodic T=7 P=1, pause 10 cycles at count 4: first tick moves 16 -> 26
    cyc(0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 4'd7, 4'd1);
    e0 = ecnt;
    run_until_count(4'd4, 40);
    for (int k = 0; k < 10; k++) begin
      cyc(0, 1, 0, 1, 4'd7, 4'd1);
      chk("t3_paused", paused, 1);
      chk("t3_hold_cnt", count, 4);
      chk("t3_hold_tick", tick, 0);
    end
    cyc(1, 0, 0, 1, 4'd7, 4'd1);
    chk("t3_resumed", paused, 0);
    while (tick !== 1'b1 && ecnt - e0 < 60) nop();
    chk("t3_tick_lat", ecnt - e0, 26);

    // abort+pause together at count 2, then start ignored mid-run
    cyc(0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 4'd7, 4'd0);
    run_until_count(4'd2, 20);
    cyc(0, 1, 1, 1, 4'd7, 4'd0);
    chk("t4_cnt", count, 0);
    chk("t4_busy", busy, 0);
    chk("t4_paused", paused, 0);
    cyc(1, 0, 0, 1, 4'd5, 4'd0);
    nop();
    cyc(1, 0, 0, 0, 4'd1, 4'd0);
    maxc = 0;
    for (int k = 0; k < 12; k++) begin
      nop();
      if (count > maxc) maxc = count;
    end
    chk("t4_max_cnt", maxc, 5);
    chk("t4_still_busy", busy, 1);

    // terminal=0: tick every cycle; terminal=15: full wrap
    cyc(0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 4'd0, 4'd0);
    for (int k = 0; k < 5; k++) begin
      nop();
      chk("t5_tick", tick, 1);
      chk("t5_cnt", count, 0);
    end
    cyc(0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 4'd15, 4'd0);
    seen = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      nop();
      chk("t5_wrap_cnt", count, k % 16);
      if (tick) seen = 1'b1;
    end
    chk("t5_wrap_tick", seen, 1);

    // async reset mid-run at count 9, then relaunch with new parameters
    cyc(0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 4'd15, 4'd0);
    run_until_count(4'd9, 20);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_cnt", count, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_tick", tick, 0);
    chk("t6_rst_done", done, 0);
    cyc(0, 0, 0, 1, 4'd15, 4'd0);
    reset = 1'b0;
    nop();
    chk("t6_idle", busy, 0);
    cyc(1, 0, 0, 0, 4'd3, 4'd0);
    chk("t6_launch_cnt", count, 0);
    for (int k = 0; k < 5; k++) nop();
    chk("t6_done", done, 1);
    chk("t6_final_cnt", count, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
